// File: rtl/falling_edge_strobe_tx.sv
// falling_edge_strobe_tx: queues event pulses and emits timed HIGH strobes whose falling edges mark events; optional FES_OVERFLOW_FLAG_EN adds a sticky overflow flag
module falling_edge_strobe_tx #(
  parameter int HIGH_CYCLES = 4,
  parameter int LOW_CYCLES  = 2,
  parameter int MAX_PENDING = 15,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in,
  output logic             out,
  output logic             busy,
  output logic [CNT_W-1:0] pending
`ifdef FES_OVERFLOW_FLAG_EN
  ,
  output logic             overflow
`endif
);
  localparam int TMAX = HIGH_CYCLES > LOW_CYCLES ? HIGH_CYCLES : LOW_CYCLES;
  localparam int TW = $clog2(TMAX);
  localparam logic [TW-1:0] H_END = TW'(HIGH_CYCLES - 1);
  localparam logic [TW-1:0] L_END = TW'(LOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] P_MAX = CNT_W'(MAX_PENDING);
  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
  state_t state, state_nxt;
  logic [TW-1:0] timer;
  logic work, start, deq, acc, drop;
  always_comb begin
    work = pending != '0 || in;
    state_nxt = state == IDLE ? (work ? HIGH : IDLE) :
                state == HIGH ? (timer == H_END ? LOW : HIGH) :
                (timer == L_END ? (work ? HIGH : IDLE) : LOW);
    start = state_nxt == HIGH && state != HIGH;
    deq = start && pending != '0;
    // an event arriving when a strobe starts from an empty queue rides that strobe directly
    acc = in && !(start && pending == '0);
    drop = acc && !deq && pending == P_MAX;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      timer <= '0;
      out <= 1'b0;
      pending <= '0;
    end else begin
      state <= state_nxt;
      timer <= (state_nxt != state || state == IDLE) ? '0 : timer + TW'(1);
      out <= state_nxt == HIGH;
      pending <= (acc && !deq && !drop) ? pending + CNT_W'(1) :
                 (deq && !acc) ? pending - CNT_W'(1) : pending;
    end
  end
  assign busy = state != IDLE || pending != '0;
`ifdef FES_OVERFLOW_FLAG_EN
  always_ff @(posedge clk) begin
    if (reset) overflow <= 1'b0;
    else if (drop) overflow <= 1'b1;
  end
`endif
endmodule

// File: tb/tb_falling_edge_strobe_tx.sv
// tb_falling_edge_strobe_tx: scoreboard bench; a timeline model predicts out/busy/pending per cycle
module tb_falling_edge_strobe_tx;
  localparam int H = 4, L = 2, M = 15;
  logic clk = 1'b0, reset = 1'b1, in = 1'b0;
  logic out, busy;
  logic [3:0] pending;
`ifdef FES_OVERFLOW_FLAG_EN
  logic overflow;
`endif
  typedef struct packed {logic o; logic b; logic [3:0] p; logic f;} exp_t;
  exp_t q[$];
  int checks = 0, failures = 0;
  int edge_n = 0, m_pend = 0, s_last = -100, nxt_ok = 0;
  bit m_ovf = 1'b0;

  falling_edge_strobe_tx dut (
    .clk(clk), .reset(reset), .in(in), .out(out), .busy(busy), .pending(pending)
`ifdef FES_OVERFLOW_FLAG_EN
    , .overflow(overflow)
`endif
  );

  always #5 clk = ~clk;

  // Strobes are placed on an absolute edge timeline: a strobe begun at edge s is high
  // after edges s..s+H-1 and forbids another start before edge s+H+L.
  task automatic drive(input bit r, input bit i);
    exp_t e;
    bit start, deq, acc;
    @(negedge clk);
    reset = r;
    in = i;
    edge_n++;
    if (r) begin
      m_pend = 0; s_last = -100; nxt_ok = 0; m_ovf = 1'b0;
    end else begin
      start = (m_pend > 0 || i) && edge_n >= nxt_ok;
      deq = start && m_pend > 0;
      acc = i && !(start && m_pend == 0);
      if (start) begin s_last = edge_n; nxt_ok = edge_n + H + L; end
      if (acc && !deq) begin
        if (m_pend < M) m_pend++;
        else m_ovf = 1'b1;
      end else if (deq && !acc) m_pend--;
    end
    e.o = (edge_n - s_last) < H;
    e.b = (edge_n - s_last) < H + L || m_pend != 0;
    e.p = 4'(m_pend);
    e.f = m_ovf;
    q.push_back(e);
  endtask

  task automatic chk(input string n, input int a, input int x);
    checks++;
    if (a != x) begin
      failures++;
      $display("FAIL %s t=%0t got=%0d expected=%0d", n, $time, a, x);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #3;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("out", int'(out), int'(e.o));
        chk("busy", int'(busy), int'(e.b));
        chk("pending", int'(pending), int'(e.p));
`ifdef FES_OVERFLOW_FLAG_EN
        chk("overflow", int'(overflow), int'(e.f));
`endif
      end
    end
  end

  task automatic run(input bit i, input int n);
    for (int k = 0; k < n; k++) drive(1'b0, i);
  endtask

  initial begin
    int dens;
    for (int k = 0; k < 3; k++) drive(1'b1, 1'b0);
    run(1'b0, 20);
    run(1'b1, 1); run(1'b0, 10);
    run(1'b1, 3); run(1'b0, 25);
    run(1'b1, 20); run(1'b0, 110);
    run(1'b1, 4); run(1'b0, 2); run(1'b1, 1); run(1'b0, 40);
    run(1'b1, 1); run(1'b0, 2); drive(1'b1, 1'b0); run(1'b0, 3);
    run(1'b1, 1); run(1'b0, 10);
    dens = 30;
    for (int k = 0; k < 1500; k++) begin
      if (k % 100 == 0) dens = int'($urandom_range(0, 100));
      drive($urandom_range(0, 199) == 0, $urandom_range(0, 99) < dens);
    end
    run(1'b0, 120);
    @(posedge clk);
    #4;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d expected=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
